// File: rtl/hazard_stall_control.sv
// Hazard and stall control: load-use interlock, branch flush and
// multdiv handshake FSM with a 64-cycle timeout.
// Ports:
//   clock, reset_n          sole clock, async active-low reset
//   FDIR, DXIR              instructions in F/D and D/X latches
//   branch_taken            X-stage taken branch/jump for DXIR
//   md_ready                multdiv result ready
//   stall_fd, stall_dx      hold PC+F/D, hold D/X
//   nop_dx, nop_xm          load nop into D/X, X/M
//   flush                   kill F/D and D/X
//   md_start, md_timeout    operand capture pulse, timeout pulse
module hazard_stall_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] FDIR,
  input  logic [31:0] DXIR,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        flush,
  output logic        md_start,
  output logic        md_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mdState_t;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  mdState_t   state;
  logic [5:0] cnt;
  logic       mdStartQ;

  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAluOp;
  logic       rsHit, rtHit, rdHit;
  logic       fdReadsDx;
  logic       dxIsMd;
  logic       loadUse;
  logic       mdStall;

  assign fdOp    = FDIR[31:27];
  assign fdRd    = FDIR[26:22];
  assign fdRs    = FDIR[21:17];
  assign fdRt    = FDIR[16:12];
  assign dxOp    = DXIR[31:27];
  assign dxRd    = DXIR[26:22];
  assign dxAluOp = DXIR[6:2];

  assign rsHit = (fdRs == dxRd);
  assign rtHit = (fdRt == dxRd);
  assign rdHit = (fdRd == dxRd);

  // sw data (rd) is served by the memory bypass, only its base
  // register can interlock.
  always_comb begin
    fdReadsDx = 1'b0;
    unique case (1'b1)
      (fdOp == OP_ALU):  fdReadsDx = rsHit | rtHit;
      (fdOp == OP_ADDI): fdReadsDx = rsHit;
      (fdOp == OP_LW):   fdReadsDx = rsHit;
      (fdOp == OP_SW):   fdReadsDx = rsHit;
      (fdOp == OP_BNE):  fdReadsDx = rdHit | rsHit;
      (fdOp == OP_BLT):  fdReadsDx = rdHit | rsHit;
      (fdOp == OP_JR):   fdReadsDx = rdHit;
      default:           fdReadsDx = 1'b0;
    endcase
  end

  assign dxIsMd = (dxOp == OP_ALU) &&
                  ((dxAluOp == 5'd6) || (dxAluOp == 5'd7));

  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   fdReadsDx;

  // A mul/div under a taken branch is killed, so it never stalls.
  assign mdStall = ((state == IDLE) && dxIsMd && !branch_taken) ||
                   (state == START) || (state == WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      mdStartQ <= 1'b0;
    end else begin
      mdStartQ <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dxIsMd && !branch_taken) begin
            state    <= START;
            cnt      <= 6'd0;
            mdStartQ <= 1'b1;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (md_ready || (cnt == 6'd63))
            state <= DONE;
          else
            cnt <= cnt + 6'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are held low while reset is asserted, even if DX
  // still holds a mul/div.
  assign flush      = reset_n & branch_taken;
  assign stall_dx   = reset_n & mdStall;
  assign nop_xm     = reset_n & mdStall;
  assign stall_fd   = reset_n &
                      (mdStall | (loadUse & !branch_taken));
  assign nop_dx     = reset_n &
                      (branch_taken | (loadUse & !mdStall));
  assign md_start   = mdStartQ;
  assign md_timeout = reset_n & (state == WAIT) &
                      (cnt == 6'd63) & !md_ready;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Bench for hazard_stall_control: vector table for the
// combinational hazards, hand sequences for the multdiv FSM.
module tb_hazard_stall_control;

  logic        clock;
  logic        reset_n;
  logic [31:0] FDIR;
  logic [31:0] DXIR;
  logic        branch_taken;
  logic        md_ready;
  logic        stall_fd, stall_dx, nop_dx, nop_xm;
  logic        flush, md_start, md_timeout;

  hazard_stall_control dut (
    .clock(clock),
    .reset_n(reset_n),
    .FDIR(FDIR),
    .DXIR(DXIR),
    .branch_taken(branch_taken),
    .md_ready(md_ready),
    .stall_fd(stall_fd),
    .stall_dx(stall_dx),
    .nop_dx(nop_dx),
    .nop_xm(nop_xm),
    .flush(flush),
    .md_start(md_start),
    .md_timeout(md_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {stall_fd, stall_dx, nop_dx, nop_xm, flush, md_start, md_timeout}
  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1010000;
  localparam logic [6:0] FL   = 7'b0010100;
  localparam logic [6:0] MDS  = 7'b1101000;
  localparam logic [6:0] MST  = 7'b1101010;
  localparam logic [6:0] TMO  = 7'b1101001;

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        bt;
    logic [6:0]  exp;
  } vec_t;

  vec_t       vecs[19];
  logic [6:0] sbq[$];
  int         compared = 0;
  int         mismatched = 0;

  function automatic logic [31:0] rtype(
    input logic [4:0] rd, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] aluop);
    return {5'd0, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(
    input logic [4:0] op, input logic [4:0] rd,
    input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic push(input logic [6:0] e);
    sbq.push_back(e);
  endtask

  task automatic cmp(input string name);
    logic [6:0] got;
    logic [6:0] e;
    got = {stall_fd, stall_dx, nop_dx, nop_xm,
           flush, md_start, md_timeout};
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      e = sbq.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL %s: got %b want %b", name, got, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] lw3, mulI, divI;

  initial begin
    lw3  = itype(5'd8, 5'd3, 5'd0, 17'd0);
    mulI = rtype(5'd1, 5'd2, 5'd3, 5'd6);
    divI = rtype(5'd1, 5'd2, 5'd3, 5'd7);

    vecs[0]  = '{rtype(4,3,5,0), lw3, 1'b0, LU};
    vecs[1]  = '{rtype(4,3,5,0), 32'd0, 1'b0, ZERO};
    vecs[2]  = '{rtype(4,5,3,0), lw3, 1'b0, LU};
    vecs[3]  = '{rtype(4,5,6,0), lw3, 1'b0, ZERO};
    vecs[4]  = '{itype(7,3,6,0), lw3, 1'b0, ZERO};
    vecs[5]  = '{itype(7,6,3,0), lw3, 1'b0, LU};
    vecs[6]  = '{itype(5,4,3,1), lw3, 1'b0, LU};
    vecs[7]  = '{itype(8,4,3,0), lw3, 1'b0, LU};
    vecs[8]  = '{itype(2,3,7,0), lw3, 1'b0, LU};
    vecs[9]  = '{itype(6,7,3,0), lw3, 1'b0, LU};
    vecs[10] = '{itype(4,3,0,0), lw3, 1'b0, LU};
    vecs[11] = '{itype(4,0,3,0), lw3, 1'b0, ZERO};
    vecs[12] = '{rtype(4,0,5,0),
                 itype(8,0,1,0), 1'b0, ZERO};
    vecs[13] = '{rtype(4,3,5,0), lw3, 1'b1, FL};
    vecs[14] = '{rtype(4,3,5,0),
                 rtype(3,1,2,0), 1'b0, ZERO};
    vecs[15] = '{32'd0, mulI, 1'b1, FL};
    vecs[16] = '{itype(5,4,5,17'h03000), lw3, 1'b0, ZERO};
    vecs[17] = '{itype(1,3,3,0), lw3, 1'b0, ZERO};
    vecs[18] = '{itype(2,3,7,0), lw3, 1'b1, FL};

    reset_n      = 1'b0;
    FDIR         = 32'd0;
    DXIR         = 32'd0;
    branch_taken = 1'b0;
    md_ready     = 1'b0;
    push(ZERO);
    #2 cmp("reset_state");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      FDIR         = vecs[i].fd;
      DXIR         = vecs[i].dx;
      branch_taken = vecs[i].bt;
      push(vecs[i].exp);
      #2 cmp($sformatf("vec%0d", i));
    end
    @(negedge clock);
    FDIR = 32'd0;
    DXIR = 32'd0;
    branch_taken = 1'b0;

    tick();
    DXIR = mulI;
    push(MDS);
    #1 cmp("mul_idle");
    tick(); push(MST); #1 cmp("mul_start");
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) md_ready = 1'b1;
      push(MDS);
      #1 cmp($sformatf("mul_wait%0d", i));
    end
    tick();
    md_ready = 1'b0;
    push(ZERO);
    #1 cmp("mul_done");
    tick(); push(MDS); #1 cmp("b2b_idle");
    tick(); push(MST); #1 cmp("b2b_start");
    tick();
    md_ready = 1'b1;
    push(MDS);
    #1 cmp("b2b_wait1");
    tick();
    md_ready = 1'b0;
    DXIR = 32'd0;
    push(ZERO);
    #1 cmp("b2b_done");
    tick(); push(ZERO); #1 cmp("b2b_idle_after");

    tick();
    DXIR = divI;
    push(MDS);
    #1 cmp("div_idle");
    tick(); push(MST); #1 cmp("div_start");
    for (int i = 1; i <= 64; i++) begin
      tick();
      push(i == 64 ? TMO : MDS);
      #1 cmp($sformatf("div_wait%0d", i));
    end
    tick();
    DXIR = 32'd0;
    push(ZERO);
    #1 cmp("div_done");
    tick(); push(ZERO); #1 cmp("div_idle_after");

    tick();
    DXIR = mulI;
    push(MDS);
    #1 cmp("rst_idle");
    tick(); push(MST); #1 cmp("rst_start0");
    tick(); push(MDS); #1 cmp("rst_wait1");
    tick(); push(MDS); #1 cmp("rst_wait2");
    #1 reset_n = 1'b0;
    push(ZERO);
    #1 cmp("rst_async");
    tick(); push(ZERO); #1 cmp("rst_held");
    @(negedge clock);
    reset_n = 1'b1;
    push(MDS);
    #1 cmp("rst_rel_idle");
    tick(); push(MST); #1 cmp("rst_restart");
    tick();
    md_ready = 1'b1;
    push(MDS);
    #1 cmp("rst_wait_ready");
    tick();
    md_ready = 1'b0;
    DXIR = 32'd0;
    push(ZERO);
    #1 cmp("rst_done");

    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL sb_drain: left %0d want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_stall_control.md
HAZARD_STALL_CONTROL -- requirements
Module: hazard_stall_control

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: FDIR  in  32  instruction in F/D latch.
REQ-004 SHALL have: DXIR  in  32  instruction in D/X latch.
REQ-005 SHALL have: branch_taken  in  1  X-stage resolved taken branch/jump (bne, blt, j, jal, jr) for DXIR.
REQ-006 SHALL have: md_ready  in  1  multdiv unit result ready.
REQ-007 SHALL have: stall_fd  out  1  hold PC and F/D latch.
REQ-008 SHALL have: stall_dx  out  1  hold D/X latch.
REQ-009 SHALL have: nop_dx  out  1  load 0 (nop) into D/X.
REQ-010 SHALL have: nop_xm  out  1  load 0 (nop) into X/M.
REQ-011 SHALL have: flush  out  1  kill F/D and D/X contents.
REQ-012 SHALL have: md_start  out  1  one-cycle multdiv operand capture.
REQ-013 SHALL have: md_timeout  out  1  one-cycle timeout pulse.
REQ-014 Fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2]; op 0 ALU, 5 addi, 7 sw, 8 lw, 2 bne, 6 blt, 4 jr; mul = op 0 aluop 6, div = op 0 aluop 7.

Function
REQ-015 Load-use hazard (lu) SHALL be 1 when DX op=8, DX rd≠0 and FD instruction reads DX rd as a source.
REQ-016 Sources: ALU rs,rt; addi rs; lw rs; sw rs; bne/blt rd,rs; jr rd.
REQ-017 FD sw with rd = DX lw rd and rs ≠ DX rd SHALL NOT cause lu (covered by memory bypass).
REQ-018 lu SHALL give stall_fd=1, nop_dx=1, stall_dx=0 combinationally in the same cycle.
REQ-019 FSM states: IDLE, START, WAIT, DONE; encoded as 2 bits; registered.
REQ-020 In IDLE: DX mul/div and branch_taken=0 -> START next cycle.
REQ-021 START SHALL last one cycle, md_start=1, and then go to WAIT; md_start SHALL be 1 in no other state.
REQ-022 In WAIT: md_ready=1 -> DONE; otherwise a 6-bit counter increments.
REQ-023 The counter SHALL be cleared on entry to START.
REQ-024 In WAIT with counter=63 and md_ready=0: md_timeout=1 for one cycle, then go to DONE.
REQ-025 DONE SHALL last one cycle; no stalls asserted, so DX result advances to X/M; DONE -> IDLE unconditionally.
REQ-026 stall_fd=stall_dx=nop_xm=1 during (IDLE and DX mul/div), START and WAIT.
REQ-027 During the multdiv stall, nop_dx SHALL be 0 and lu SHALL be ignored.
REQ-028 Back-to-back mul/div: the second op is seen in IDLE after DONE and SHALL start a new sequence.
REQ-029 flush SHALL equal branch_taken, and flush SHALL also force nop_dx=1.
REQ-030 flush SHALL override lu: stall_fd=0 whenever flush=1.
REQ-031 All non-FSM outputs SHALL be combinational from current inputs and state; no write to r0 creates a hazard.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE, counter 0, md_start=0 and md_timeout=0, including mid-WAIT.
REQ-033 After release, the first rising edge SHALL evaluate from IDLE; a pending mul/div in DX restarts from START.

Verification
REQ-034 DX=lw r3; FD=add r4,r3,r5 -> stall_fd=1, nop_dx=1 for exactly one cycle, then 0.
REQ-035 DX=lw r3; FD=sw r3,0(r6) -> no stall; FD=sw r6,0(r3) -> one-cycle stall.
REQ-036 DX=mul; md_ready high 5 cycles after md_start -> md_start one pulse; stall_fd high 7 cycles total (IDLE, START, WAIT×5); DONE releases.
REQ-037 DX=div; md_ready never -> md_timeout pulses on the 64th WAIT cycle, DONE, IDLE; stalls drop.
REQ-038 DX=bne taken while FD=lw-dependent add -> flush=1, nop_dx=1, stall_fd=0.
REQ-039 reset_n low during WAIT -> all outputs 0 asynchronously; after release with DX=mul -> START on the next edge.
